// File: rtl/msg_bank_buffer_pkg.sv
// Shared types and helpers for the multi-bank message buffer.
// Bank pointers are a fixed 2 bits wide, enough for up to four banks.
package msg_bank_buffer_pkg;

   typedef enum logic [1:0] {
      BankFree    = 2'd0,
      BankFilling = 2'd1,
      BankFull    = 2'd2
   } bank_st_e;

   typedef enum logic {
      HsIdle = 1'b0,
      HsAck  = 1'b1
   } hs_st_e;

   // Advance a bank pointer, wrapping at num (which need not be a power of two).
   function automatic logic [1:0] ptr_inc(input logic [1:0] ptr, input int unsigned num);
      if ({30'd0, ptr} + 32'd1 >= num) begin
         return 2'd0;
      end
      return ptr + 2'd1;
   endfunction

endpackage

// File: rtl/msg_bank_ram.sv
// Simple dual-port RAM holding all banks back to back, addressed as {bank, addr}.
// Registered read, no reset on contents.
module msg_bank_ram #(
   parameter int unsigned DATA_W    = 8,
   parameter int unsigned ADDR_W    = 8,
   parameter int unsigned NUM_BANKS = 2
) (
   input  logic              clk_i,
   input  logic              we_i,
   input  logic [1:0]        wbank_i,
   input  logic [ADDR_W-1:0] waddr_i,
   input  logic [DATA_W-1:0] wdata_i,
   input  logic              re_i,
   input  logic [1:0]        rbank_i,
   input  logic [ADDR_W-1:0] raddr_i,
   output logic [DATA_W-1:0] rdata_o
);

   localparam int unsigned Depth = NUM_BANKS << ADDR_W;
   localparam int unsigned RamAw = $clog2(Depth);

   logic [DATA_W-1:0] mem_q [Depth];
   logic [DATA_W-1:0] rdata_q;
   logic [RamAw-1:0]  widx;
   logic [RamAw-1:0]  ridx;

   // Bank index is always below NUM_BANKS, so dropping unused top bits is lossless.
   assign widx = RamAw'({wbank_i, waddr_i});
   assign ridx = RamAw'({rbank_i, raddr_i});

   always_ff @(posedge clk_i) begin
      if (we_i) begin
         mem_q[widx] <= wdata_i;
      end
      if (re_i) begin
         rdata_q <= mem_q[ridx];
      end
   end

   assign rdata_o = rdata_q;

endmodule

// File: rtl/msg_bank_buffer.sv
// Multi-bank message buffer: write side fills banks, commits or discards on end_msg,
// read side consumes complete messages in FIFO order. MSG_BANK_BUFFER_STATS_EN adds counters.
module msg_bank_buffer
   import msg_bank_buffer_pkg::*;
#(
   parameter int unsigned DATA_W    = 8,
   parameter int unsigned ADDR_W    = 8,
   parameter int unsigned NUM_BANKS = 2
) (
   input  logic              clk,
   input  logic              rst_l,
   input  logic              wr_req,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [DATA_W-1:0] wr_data,
   output logic              wr_rdy,
   input  logic              end_msg,
   input  logic              msg_ok,
   input  logic              msg_line,
   input  logic              rd_req,
   input  logic [ADDR_W-1:0] rd_addr,
   output logic [DATA_W-1:0] rd_data,
   output logic              rd_rdy,
   input  logic              rd_release,
   output logic              msg_avail,
   output logic [2:0]        msg_count,
   output logic [ADDR_W:0]   head_len,
   output logic              head_line
`ifdef MSG_BANK_BUFFER_STATS_EN
   ,
   output logic [7:0]        drop_cnt,
   output logic [7:0]        bad_cnt
`endif
);

   hs_st_e          wr_st_q, wr_st_d;
   hs_st_e          rd_st_q, rd_st_d;
   logic [1:0]      wr_bank_q, wr_bank_d;
   logic [1:0]      rd_bank_q, rd_bank_d;
   bank_st_e        bank_st_q [NUM_BANKS];
   bank_st_e        bank_st_d [NUM_BANKS];
   logic [ADDR_W:0] len_q [NUM_BANKS];
   logic [ADDR_W:0] len_d [NUM_BANKS];
   logic            line_q [NUM_BANKS];
   logic            line_d [NUM_BANKS];
   logic [ADDR_W:0] head_len_q;
   logic            head_line_q;
   logic            rd_hit_q, rd_hit_d;

   bank_st_e        wr_cur_st, wr_nxt_st, rd_cur_st;
   logic [ADDR_W:0] wr_cur_len, rd_cur_len, wr_len, addr_p1;
   logic            rd_cur_line;
   logic            wr_accept, rd_accept, overflow, wr_store;
   logic            commit, discard, rel_head;
   logic [2:0]      count;
   logic [DATA_W-1:0] ram_rdata;

   // Per-bank views selected by the two pointers.
   always_comb begin
      wr_cur_st   = BankFree;
      wr_nxt_st   = BankFree;
      rd_cur_st   = BankFree;
      wr_cur_len  = '0;
      rd_cur_len  = '0;
      rd_cur_line = 1'b0;
      count       = 3'd0;
      for (int i = 0; i < NUM_BANKS; i++) begin
         if (wr_bank_q == 2'(i)) begin
            wr_cur_st  = bank_st_q[i];
            wr_cur_len = len_q[i];
         end
         if (ptr_inc(wr_bank_q, NUM_BANKS) == 2'(i)) begin
            wr_nxt_st = bank_st_q[i];
         end
         if (rd_bank_q == 2'(i)) begin
            rd_cur_st   = bank_st_q[i];
            rd_cur_len  = len_q[i];
            rd_cur_line = line_q[i];
         end
         if (bank_st_q[i] == BankFull) begin
            count = count + 3'd1;
         end
      end
   end

   assign msg_avail = (count != 3'd0);
   assign msg_count = count;
   assign overflow  = (wr_cur_st == BankFull);
   assign addr_p1   = {1'b0, wr_addr} + (ADDR_W+1)'(1);
   assign wr_store  = wr_accept && !overflow;
   // A write landing with end_msg counts toward the committed length.
   assign wr_len    = (wr_store && (addr_p1 > wr_cur_len)) ? addr_p1 : wr_cur_len;
   assign commit    = end_msg && msg_ok && !overflow;
   assign discard   = end_msg && !msg_ok && !overflow;
   assign rel_head  = rd_release && msg_avail;

   // Handshake FSMs.
   always_comb begin
      wr_st_d   = wr_st_q;
      wr_accept = 1'b0;
      unique case (wr_st_q)
         HsIdle: begin
            if (wr_req) begin
               wr_accept = 1'b1;
               wr_st_d   = HsAck;
            end
         end
         HsAck:   wr_st_d = HsIdle;
         default: wr_st_d = HsIdle;
      endcase
   end

   always_comb begin
      rd_st_d   = rd_st_q;
      rd_hit_d  = rd_hit_q;
      rd_accept = 1'b0;
      unique case (rd_st_q)
         HsIdle: begin
            if (rd_req) begin
               rd_accept = 1'b1;
               rd_hit_d  = msg_avail;
               rd_st_d   = HsAck;
            end
         end
         HsAck:   rd_st_d = HsIdle;
         default: rd_st_d = HsIdle;
      endcase
   end

   assign wr_rdy  = (wr_st_q == HsAck);
   assign rd_rdy  = (rd_st_q == HsAck);
   assign rd_data = (rd_rdy && rd_hit_q) ? ram_rdata : '0;

   // Bank bookkeeping and pointer movement.
   always_comb begin
      for (int i = 0; i < NUM_BANKS; i++) begin
         bank_st_d[i] = bank_st_q[i];
         len_d[i]     = len_q[i];
         line_d[i]    = line_q[i];
         if (wr_bank_q == 2'(i)) begin
            if (wr_store) begin
               bank_st_d[i] = BankFilling;
               len_d[i]     = wr_len;
            end
            if (commit) begin
               bank_st_d[i] = BankFull;
               len_d[i]     = wr_len;
               line_d[i]    = msg_line;
            end else if (discard) begin
               bank_st_d[i] = BankFree;
               len_d[i]     = '0;
            end
         end
         if (rel_head && (rd_bank_q == 2'(i))) begin
            bank_st_d[i] = BankFree;
            len_d[i]     = '0;
         end
      end

      wr_bank_d = wr_bank_q;
      // A stalled writer sits on its own full bank until the next one frees up.
      if ((commit || overflow) && (wr_nxt_st == BankFree)) begin
         wr_bank_d = ptr_inc(wr_bank_q, NUM_BANKS);
      end
      rd_bank_d = rel_head ? ptr_inc(rd_bank_q, NUM_BANKS) : rd_bank_q;
   end

   always_ff @(posedge clk or negedge rst_l) begin
      if (!rst_l) begin
         wr_st_q     <= HsIdle;
         rd_st_q     <= HsIdle;
         wr_bank_q   <= 2'd0;
         rd_bank_q   <= 2'd0;
         rd_hit_q    <= 1'b0;
         head_len_q  <= '0;
         head_line_q <= 1'b0;
         for (int i = 0; i < NUM_BANKS; i++) begin
            bank_st_q[i] <= BankFree;
            len_q[i]     <= '0;
            line_q[i]    <= 1'b0;
         end
      end else begin
         wr_st_q     <= wr_st_d;
         rd_st_q     <= rd_st_d;
         wr_bank_q   <= wr_bank_d;
         rd_bank_q   <= rd_bank_d;
         rd_hit_q    <= rd_hit_d;
         head_len_q  <= (rd_cur_st == BankFull) ? rd_cur_len : '0;
         head_line_q <= (rd_cur_st == BankFull) ? rd_cur_line : 1'b0;
         for (int i = 0; i < NUM_BANKS; i++) begin
            bank_st_q[i] <= bank_st_d[i];
            len_q[i]     <= len_d[i];
            line_q[i]    <= line_d[i];
         end
      end
   end

   assign head_len  = head_len_q;
   assign head_line = head_line_q;

`ifdef MSG_BANK_BUFFER_STATS_EN
   logic [7:0] drop_cnt_q, bad_cnt_q;

   always_ff @(posedge clk or negedge rst_l) begin
      if (!rst_l) begin
         drop_cnt_q <= 8'd0;
         bad_cnt_q  <= 8'd0;
      end else begin
         if (end_msg && overflow && (drop_cnt_q != 8'hff)) begin
            drop_cnt_q <= drop_cnt_q + 8'd1;
         end
         if (discard && (bad_cnt_q != 8'hff)) begin
            bad_cnt_q <= bad_cnt_q + 8'd1;
         end
      end
   end

   assign drop_cnt = drop_cnt_q;
   assign bad_cnt  = bad_cnt_q;
`endif

   msg_bank_ram #(
      .DATA_W    (DATA_W),
      .ADDR_W    (ADDR_W),
      .NUM_BANKS (NUM_BANKS)
   ) u_ram (
      .clk_i   (clk),
      .we_i    (wr_store),
      .wbank_i (wr_bank_q),
      .waddr_i (wr_addr),
      .wdata_i (wr_data),
      .re_i    (rd_accept),
      .rbank_i (rd_bank_q),
      .raddr_i (rd_addr),
      .rdata_o (ram_rdata)
   );

endmodule

// File: doc/msg_bank_buffer.md
Name: msg_bank_buffer

Overview:
- Parametrised multi-bank message buffer between the hi-speed protocol receiver's RAM write port (REQ/RDY handshake) and a transmitter-style RAM read port.
- Successor to the fixed single-source slave RAM model: N banks, configurable width and depth, commit/discard on message end, FIFO ordering of complete messages.
- Sits beside the protocol rx/tx core in the top level, on the system clock.

Parameters:
- DATA_W, 8, data byte width.
- ADDR_W, 8, in-bank address width; bank depth = 2**ADDR_W.
- NUM_BANKS, 2, number of banks, 2..4; need not be a power of two.

Ports:
- clk  in  1  system clock.
- rst_l  in  1  asynchronous active-low reset.
- wr_req  in  1  write request (level, held until wr_rdy).
- wr_addr  in  ADDR_W  write address within the current bank.
- wr_data  in  DATA_W  write data.
- wr_rdy  out  1  one-cycle write acknowledge.
- end_msg  in  1  one-cycle message-end pulse.
- msg_ok  in  1  sampled with end_msg: 1 = commit, 0 = discard.
- msg_line  in  1  sampled with end_msg: receiving line (0 = COM1, 1 = COM2).
- rd_req  in  1  read request (level, held until rd_rdy).
- rd_addr  in  ADDR_W  read address within the head bank.
- rd_data  out  DATA_W  read data; valid while rd_rdy = 1.
- rd_rdy  out  1  one-cycle read acknowledge.
- rd_release  in  1  one-cycle pulse that frees the head bank.
- msg_avail  out  1  at least one committed bank.
- msg_count  out  3  number of committed banks.
- head_len  out  ADDR_W+1  byte count of the head message.
- head_line  out  1  line of the head message.

Behaviour:
- Reset: all banks FREE, wr_bank = rd_bank = 0, wr_rdy = rd_rdy = 0, rd_data = 0, msg_avail = 0, msg_count = 0, head_len = 0, head_line = 0. Memory contents are not reset.
- Each bank has a state: FREE, FILLING, or FULL. The write pointer owns one bank, marked FILLING on its first accepted write.
- Write FSM states: IDLE and ACK.
  - IDLE with wr_req = 1: store the data if wr_bank is not FULL, then go to ACK.
  - ACK: wr_rdy = 1 for exactly one cycle, then IDLE.
  - A request held through ACK is accepted again only after returning to IDLE, so the minimum is 2 cycles per write.
- Length tracking: the bank's length register = max(length, wr_addr+1), computed in ADDR_W+1 bits. An address of 2**ADDR_W-1 gives length 2**ADDR_W with no wrap.
- end_msg with msg_ok = 1 and the write bank not FULL:
  - Bank becomes FULL; length and line are stored.
  - wr_bank advances modulo NUM_BANKS, to the next bank only if that bank is FREE; otherwise the write side stalls.
  - A commit with length 0 (no writes) is still committed with length 0.
- end_msg with msg_ok = 0: the bank's length is cleared and the bank returns to FREE; wr_bank does not advance.
- Overflow: while wr_bank points at a FULL bank, writes are acknowledged normally, data is dropped, and end_msg is ignored.
- end_msg coinciding with an accepted write: the write is applied first and counted in the committed length.
- Read side:
  - rd_req in IDLE returns rd_data from bank rd_bank at rd_addr, with rd_rdy pulsed 1 cycle later.
  - Read FSM states: IDLE and ACK, symmetric with the write side.
  - Reads while msg_avail = 0 are acknowledged and return 0.
- rd_release with msg_avail = 1: bank rd_bank becomes FREE and rd_bank advances modulo NUM_BANKS. With msg_avail = 0, rd_release is ignored.
- Commit and release in the same cycle: both take effect and msg_count is unchanged. If the write side was stalled on the released bank, wr_bank advances on the next cycle.
- head_len and head_line are registered and update the cycle after rd_bank or its state changes.

Optional Feature:
- Macro: MSG_BANK_BUFFER_STATS_EN.
- When defined, adds two ports:
  - drop_cnt, out, 8: saturating count of end_msg events ignored while overflowed.
  - bad_cnt, out, 8: saturating count of discards (msg_ok = 0).
  - Both reset to 0.
- When undefined, these ports and their counters are absent and behaviour is otherwise identical.

Decomposition:
- Shared package: bank state encoding (FREE, FILLING, FULL), handshake FSM state encoding (IDLE, ACK), and a pointer-increment-modulo function.
- One sub-module, msg_bank_ram: a simple dual-port RAM with depth NUM_BANKS*2**ADDR_W, address {bank, addr}, registered read.

Test Plan:
- Write 0x11, 0x22, 0x33 at addresses 0..2, then end_msg with msg_ok = 1 and msg_line = 1 -> msg_avail = 1, msg_count = 1, head_len = 3, head_line = 1; reading addresses 0..2 returns 0x11, 0x22, 0x33, each rd_rdy arriving 1 cycle after rd_req.
- Write to address 5, then end_msg with msg_ok = 0 -> msg_count = 0; the next message in the same bank with a write to address 0 gives head_len = 1.
- NUM_BANKS = 2, commit 2 messages, write a third message and end_msg -> wr_rdy still pulses, msg_count stays 2, and drop_cnt = 1 when MSG_BANK_BUFFER_STATS_EN is defined.
- rd_release in the same cycle as an end_msg commit while 1 bank is full -> msg_count stays 1 and the head moves to the new message.
- Write to address 255 with ADDR_W = 8, then commit -> head_len = 256.
- Assert rst_l low for 1 cycle mid-write -> wr_rdy = 0 immediately, msg_count = 0, and a subsequent write is accepted into bank 0.
